medidor_pwm_ventoinha: RTL
==========================

// Module: medidor_pwm_ventoinha
// PURPOSE
//   Receive end of the fan PWM link: measures period and high time of an incoming
//   PWM (nominal 20 kHz, 2500 clocks) and decodes them back to the 3-bit fan level.
//   Used for loopback checking of the fan controller and for reading external PWM
//   commands. Flags loss of signal and out-of-tolerance periods.
// PARAMETERS
//   CONF_PERIODO  2500  nominal period in clocks
//   TOL_PERIODO   125   accepted |measured - CONF_PERIODO| in clocks
//   LARGURA_000..LARGURA_111  313,625,939,1250,1562,1875,2187,2500  nominal high times
//   TIMEOUT       5000  clocks without a rising edge before declaring constant level
// PORTS
//   clock          in   1  system clock
//   reset          in   1  asynchronous, active-low reset
//   pwm_entrada    in   1  asynchronous PWM input
//   nivel          out  3  decoded fan level
//   nivel_valido   out  1  nivel reflects the current input
//   sem_sinal      out  1  input held low for TIMEOUT clocks
//   erro_periodo   out  1  one-cycle pulse: period outside tolerance
//   largura_medida out  W  last accepted high time, W = $clog2(TIMEOUT+1)
// BEHAVIOUR
//   - Reset: nivel=000, nivel_valido=0, sem_sinal=0, erro_periodo=0, largura_medida=0,
//     counters 0, FSM=ESPERA. Reset mid-period discards the partial measurement.
//   - pwm_entrada -> 2-FF synchronizer -> rising-edge detect. E0 = first clock edge
//     sampling 1; the edge is detected in cycle E1..E2; outputs update at E2.
//   - cont_periodo counts clocks between detected rising edges; cont_alto counts
//     clocks with synchronized input = 1. Both saturate at TIMEOUT.
//   - FSM: ESPERA (wait for first rising edge; no result) -> MEDINDO on edge.
//     MEDINDO: on each rising edge, evaluate the finished period, then clear both
//     counters. Saturation with input 0 -> SEM_SINAL; with input 1 -> ALTO_FIXO.
//     SEM_SINAL: sem_sinal=1, nivel=000, nivel_valido=0.
//     ALTO_FIXO: nivel=111, nivel_valido=1, sem_sinal=0.
//     Both leave to MEDINDO on the next rising edge (counters cleared; no result
//     for that edge).
//   - Evaluation: |cont_periodo - CONF_PERIODO| > TOL_PERIODO -> erro_periodo pulse;
//     nivel and largura_medida held. Otherwise largura_medida=cont_alto and nivel is
//     quantized to the nearest LARGURA_xxx: level k is chosen when cont_alto <
//     floor((LARGURA_k + LARGURA_k+1)/2) (first match). Default thresholds are
//     469,782,1094,1406,1718,2031,2343; ties go to the upper level. nivel_valido=1.
//   - Arithmetic is unsigned at width W; the difference compare must not wrap.
//   - Edge detected on the same clock as saturation: the edge wins.
// CONFIGURATION
//   FILTRO_NIVEL_EN defined: a new quantized level is applied only after two
//     consecutive accepted periods decode to the same value. erro_periodo does not
//     reset the pending candidate. largura_medida still updates every accepted period.
//   FILTRO_NIVEL_EN undefined: nivel updates on every accepted period.
// STRUCTURE
//   - ventoinha_defs.vh: level encodings (NIVEL_000..111), default LARGURA values,
//     CONF_PERIODO, FSM state encodings; shared with the fan PWM generator.
//   - Sub-module sincronizador_borda: 2-FF sync plus registered rising-edge pulse.
//   - Top level: counters, FSM, quantizer, output registers.
// TESTING
//   1. Period 2500, high 1250 -> from the 2nd rising edge: nivel=011, valido=1,
//      largura_medida=1250.
//   2. High 313/939/2187/2500-1 -> 000/010/110/111. Boundary: high 468 -> 000,
//      high 469 -> 001.
//   3. Input low for 5000 clocks -> sem_sinal=1, valido=0, nivel=000. Input high for
//      5000 clocks -> nivel=111, valido=1. Restart PWM -> measurement resumes.
//   4. Period 2200 (outside 2500±125) -> erro_periodo pulses 1 cycle, nivel held.
//      Period 2600 -> accepted.
//   5. reset=0 mid-period while nivel=101 -> all outputs 0 asynchronously.
//      After release -> ESPERA, no result until the 2nd rising edge.
//   6. FILTRO_NIVEL_EN: alternate high 1250/1562 -> nivel stays 011.
//      Two consecutive 1562 -> nivel=100.

Source files
------------

// File: rtl/medidor_pwm_ventoinha_pkg.sv
// Shared fan PWM definitions: level encodings, nominal high times, period and FSM states.
// Also used by the fan PWM generator so both ends agree on the level table.
package medidor_pwm_ventoinha_pkg;

    localparam int CONF_PERIODO = 2500;
    localparam int TOL_PERIODO  = 125;
    localparam int TIMEOUT      = 5000;

    localparam logic [2:0] NIVEL_000 = 3'b000;
    localparam logic [2:0] NIVEL_001 = 3'b001;
    localparam logic [2:0] NIVEL_010 = 3'b010;
    localparam logic [2:0] NIVEL_011 = 3'b011;
    localparam logic [2:0] NIVEL_100 = 3'b100;
    localparam logic [2:0] NIVEL_101 = 3'b101;
    localparam logic [2:0] NIVEL_110 = 3'b110;
    localparam logic [2:0] NIVEL_111 = 3'b111;

    localparam int unsigned LARGURA_000 = 313;
    localparam int unsigned LARGURA_001 = 625;
    localparam int unsigned LARGURA_010 = 939;
    localparam int unsigned LARGURA_011 = 1250;
    localparam int unsigned LARGURA_100 = 1562;
    localparam int unsigned LARGURA_101 = 1875;
    localparam int unsigned LARGURA_110 = 2187;
    localparam int unsigned LARGURA_111 = 2500;

    // Decision points sit halfway between neighbouring nominal widths (floored).
    localparam int unsigned LIMIAR_0 = (LARGURA_000 + LARGURA_001) / 2;
    localparam int unsigned LIMIAR_1 = (LARGURA_001 + LARGURA_010) / 2;
    localparam int unsigned LIMIAR_2 = (LARGURA_010 + LARGURA_011) / 2;
    localparam int unsigned LIMIAR_3 = (LARGURA_011 + LARGURA_100) / 2;
    localparam int unsigned LIMIAR_4 = (LARGURA_100 + LARGURA_101) / 2;
    localparam int unsigned LIMIAR_5 = (LARGURA_101 + LARGURA_110) / 2;
    localparam int unsigned LIMIAR_6 = (LARGURA_110 + LARGURA_111) / 2;

    typedef enum logic [1:0] {
        ESPERA    = 2'b00,
        MEDINDO   = 2'b01,
        SEM_SINAL = 2'b10,
        ALTO_FIXO = 2'b11
    } estado_t;

    // Nearest nominal level; a value equal to a threshold belongs to the upper level.
    function automatic logic [2:0] quantiza(input logic [31:0] alto);
        if      (alto < LIMIAR_0) return NIVEL_000;
        else if (alto < LIMIAR_1) return NIVEL_001;
        else if (alto < LIMIAR_2) return NIVEL_010;
        else if (alto < LIMIAR_3) return NIVEL_011;
        else if (alto < LIMIAR_4) return NIVEL_100;
        else if (alto < LIMIAR_5) return NIVEL_101;
        else if (alto < LIMIAR_6) return NIVEL_110;
        else                      return NIVEL_111;
    endfunction

endpackage

// File: rtl/medidor_pwm_ventoinha_sincronizador_borda.sv
// Two-flop synchronizer for the asynchronous PWM input plus rising-edge pulse.
// borda_o is high for the first cycle in which the synchronized level reads 1.
module sincronizador_borda (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic dado_i,
    output logic nivel_o,
    output logic borda_o
);

    logic meta_q;
    logic sinc_q;
    logic ant_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sinc_q <= 1'b0;
            ant_q  <= 1'b0;
        end else begin
            meta_q <= dado_i;
            sinc_q <= meta_q;
            ant_q  <= sinc_q;
        end
    end

    assign nivel_o = sinc_q;
    assign borda_o = sinc_q & ~ant_q;

endmodule

// File: rtl/medidor_pwm_ventoinha.sv
// Fan PWM receiver: measures period/high time and decodes the 3-bit fan level.
// Optional FILTRO_NIVEL_EN: a new level needs two consecutive accepted periods agreeing.
module medidor_pwm_ventoinha
    import medidor_pwm_ventoinha_pkg::*;
#(
    parameter int  PERIODO    = CONF_PERIODO,
    parameter int  TOLERANCIA = TOL_PERIODO,
    parameter int  LIMITE     = TIMEOUT,
    localparam int W          = $clog2(LIMITE + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pwm_entrada,
    output logic [2:0]   nivel,
    output logic         nivel_valido,
    output logic         sem_sinal,
    output logic         erro_periodo,
    output logic [W-1:0] largura_medida
);

    localparam logic [W-1:0] PER_W = W'(PERIODO);
    localparam logic [W-1:0] TOL_W = W'(TOLERANCIA);
    localparam logic [W-1:0] LIM_W = W'(LIMITE);
    localparam logic [W-1:0] UM_W  = W'(1);

    logic         nivel_sinc;
    logic         borda;

    estado_t      estado_q, estado_d;
    logic [W-1:0] cont_periodo_q, cont_periodo_d;
    logic [W-1:0] cont_alto_q, cont_alto_d;
    logic [2:0]   nivel_q, nivel_d;
    logic         valido_q, valido_d;
    logic         sem_q, sem_d;
    logic         erro_q, erro_d;
    logic [W-1:0] largura_q, largura_d;

    logic         saturou;
    logic [W-1:0] desvio;
    logic         fora_tol;
    logic         avalia;
    logic         aceito;
    logic         rejeitado;
    logic         aplica;
    logic [2:0]   quantizado;

    sincronizador_borda u_sinc (
        .clk_i   (clock),
        .rst_ni  (reset),
        .dado_i  (pwm_entrada),
        .nivel_o (nivel_sinc),
        .borda_o (borda)
    );

    // The edge cycle itself is the first clock of the new period (and is high),
    // so both counters restart at 1 and read exactly period/high at the next edge.
    always_comb begin
        cont_periodo_d = cont_periodo_q;
        cont_alto_d    = cont_alto_q;
        if (borda) begin
            cont_periodo_d = UM_W;
            cont_alto_d    = UM_W;
        end else begin
            if (cont_periodo_q != LIM_W)
                cont_periodo_d = cont_periodo_q + UM_W;
            if (nivel_sinc && (cont_alto_q != LIM_W))
                cont_alto_d = cont_alto_q + UM_W;
        end
    end

    assign saturou    = (cont_periodo_q == LIM_W) && !borda;
    assign desvio     = (cont_periodo_q >= PER_W) ? (cont_periodo_q - PER_W)
                                                  : (PER_W - cont_periodo_q);
    assign fora_tol   = desvio > TOL_W;
    assign avalia     = (estado_q == MEDINDO) && borda;
    assign aceito     = avalia && !fora_tol;
    assign rejeitado  = avalia && fora_tol;
    assign quantizado = quantiza(32'(cont_alto_q));

`ifdef FILTRO_NIVEL_EN
    logic [2:0] cand_q, cand_d;
    logic       cand_ok_q, cand_ok_d;

    // Out-of-tolerance periods leave the pending candidate untouched.
    always_comb begin
        cand_d    = cand_q;
        cand_ok_d = cand_ok_q;
        if (aceito) begin
            cand_d    = quantizado;
            cand_ok_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cand_q    <= NIVEL_000;
            cand_ok_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cand_ok_q <= cand_ok_d;
        end
    end

    assign aplica = aceito && cand_ok_q && (cand_q == quantizado);
`else
    assign aplica = aceito;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q       <= ESPERA;
            cont_periodo_q <= '0;
            cont_alto_q    <= '0;
            nivel_q        <= NIVEL_000;
            valido_q       <= 1'b0;
            sem_q          <= 1'b0;
            erro_q         <= 1'b0;
            largura_q      <= '0;
        end else begin
            estado_q       <= estado_d;
            cont_periodo_q <= cont_periodo_d;
            cont_alto_q    <= cont_alto_d;
            nivel_q        <= nivel_d;
            valido_q       <= valido_d;
            sem_q          <= sem_d;
            erro_q         <= erro_d;
            largura_q      <= largura_d;
        end
    end

    // An edge arriving on the saturation clock wins: saturou already excludes it.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            ESPERA: begin
                if (borda)
                    estado_d = MEDINDO;
            end
            MEDINDO: begin
                if (saturou)
                    estado_d = nivel_sinc ? ALTO_FIXO : SEM_SINAL;
            end
            SEM_SINAL, ALTO_FIXO: begin
                if (borda)
                    estado_d = MEDINDO;
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_comb begin
        nivel_d   = nivel_q;
        valido_d  = valido_q;
        sem_d     = sem_q;
        erro_d    = 1'b0;
        largura_d = largura_q;
        unique case (estado_q)
            MEDINDO: begin
                if (aceito) begin
                    largura_d = cont_alto_q;
                    if (aplica) begin
                        nivel_d  = quantizado;
                        valido_d = 1'b1;
                    end
                end else if (rejeitado) begin
                    erro_d = 1'b1;
                end else if (saturou) begin
                    if (nivel_sinc) begin
                        nivel_d  = NIVEL_111;
                        valido_d = 1'b1;
                        sem_d    = 1'b0;
                    end else begin
                        nivel_d  = NIVEL_000;
                        valido_d = 1'b0;
                        sem_d    = 1'b1;
                    end
                end
            end
            SEM_SINAL, ALTO_FIXO: begin
                if (borda)
                    sem_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign nivel          = nivel_q;
    assign nivel_valido   = valido_q;
    assign sem_sinal      = sem_q;
    assign erro_periodo   = erro_q;
    assign largura_medida = largura_q;

endmodule
